fetch_buffer: RTL and testbench

//  Instruction-fetch stage directly downstream of the program counter register.
//  - Takes the current PC and issues it to the synchronous instruction memory (1-cycle read).
//  - Queues each returned {instruction, PC} pair in a small FIFO.
//  - Presents entries to decode with a valid/ready handshake.
//  - Drives PCWrite back to the PC so the PC holds when no fetch credit is free.
//  - Flush discards all queued and in-flight fetches on branch/jump redirect.

---
 rtl/fetch_buffer.sv | 110 +++++++++++
 tb/tb_fetch_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: issues the PC to a 1-cycle instruction memory and queues the
// returned {instruction, PC} pairs for decode behind a valid/ready handshake.
module fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [AW-1:0]          PC,
    output logic                   PCWrite,
    output logic                   IMemReq,
    output logic [AW-1:0]          IMemAddr,
    input  logic [DW-1:0]          IMemData,
    input  logic                   Flush,
    output logic                   InstrValid,
    input  logic                   DecodeReady,
    output logic [DW-1:0]          InstrOut,
    output logic [AW-1:0]          PCOut,
    output logic [AW-1:0]          PCPlus4Out,
    output logic [$clog2(DEPTH):0] Count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0]   CreditLimit = DEPTH[CW:0];
    localparam logic [CW-1:0] FullCount   = DEPTH[CW-1:0];
    localparam logic [AW-1:0] PcStep      = {{(AW-3){1'b0}}, 3'd4};

    logic [DW-1:0] instr_q [DEPTH];
    logic [AW-1:0] pc_q    [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q;
    logic [AW-1:0] inflight_pc_q;
    logic [CW:0]   credit_used;
    logic          issue;
    logic          push;
    logic          pop;

    // Credit counts queued entries plus the read in flight; a same-cycle pop frees nothing.
    assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue       = !Reset && !Flush && (credit_used < CreditLimit);
    assign push        = inflight_q && !Flush;
    assign pop         = InstrValid && DecodeReady && !Flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= issue;
            inflight_pc_q <= PC;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= IMemData;
            pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    assign IMemReq    = issue;
    assign IMemAddr   = PC;
    assign PCWrite    = !Reset && (issue || Flush);
    assign InstrValid = (count_q != '0);
    assign InstrOut   = instr_q[rd_ptr_q];
    assign PCOut      = pc_q[rd_ptr_q];
    assign PCPlus4Out = pc_q[rd_ptr_q] + PcStep;
    assign Count      = count_q;

    assert property (@(posedge Clk) disable iff (Reset) !(push && count_q == FullCount))
        else $error("fetch_buffer: push into a full queue");

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomised bench for fetch_buffer: a queue-based model of the fetch stage plus a
// PC/instruction-memory environment, checked every cycle.
module tb_fetch_buffer;
    localparam int unsigned DEPTH = 4;

    logic        Clk;
    logic        Reset;
    logic [31:0] PC;
    logic        PCWrite;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemData;
    logic        Flush;
    logic        InstrValid;
    logic        DecodeReady;
    logic [31:0] InstrOut;
    logic [31:0] PCOut;
    logic [31:0] PCPlus4Out;
    logic [2:0]  Count;

    fetch_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .PC         (PC),
        .PCWrite    (PCWrite),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemData   (IMemData),
        .Flush      (Flush),
        .InstrValid (InstrValid),
        .DecodeReady(DecodeReady),
        .InstrOut   (InstrOut),
        .PCOut      (PCOut),
        .PCPlus4Out (PCPlus4Out),
        .Count      (Count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      fifo[$];
    logic        pending;
    logic [31:0] pending_pc;

    logic        cur_rst, cur_flush, cur_ready;
    logic [31:0] cur_target;
    logic [31:0] pc_reg, rst_pc;
    logic        mem_req_s;
    logic [31:0] mem_addr_s;

    logic        exp_valid, exp_issue, exp_pcwrite;
    logic [31:0] exp_count, exp_pc, exp_instr;
    logic        chk_en;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a | 32'hAB00_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    endtask

    // One clock cycle: retire the effects of the edge just passed, then drive new inputs.
    task automatic step(input logic rst, input logic flush, input logic [31:0] tgt,
                        input logic rdy);
        @(negedge Clk);
        if (cur_rst) begin
            fifo.delete();
            pending = 1'b0;
            pc_reg  = rst_pc;
        end else if (cur_flush) begin
            fifo.delete();
            pending = 1'b0;
            pc_reg  = cur_target;
        end else begin
            if (exp_valid && cur_ready) void'(fifo.pop_front());
            if (pending) begin
                entry_t e;
                e.instr = word(pending_pc);
                e.pc    = pending_pc;
                fifo.push_back(e);
            end
            pending    = exp_issue;
            pending_pc = pc_reg;
            if (exp_pcwrite) pc_reg = pc_reg + 32'd4;
        end

        IMemData = mem_req_s ? word(mem_addr_s) : $urandom();
        Reset       = rst;
        Flush       = flush;
        DecodeReady = rdy;
        PC          = pc_reg;
        cur_rst     = rst;
        cur_flush   = flush;
        cur_target  = tgt;
        cur_ready   = rdy;
        if (rst) begin
            fifo.delete();
            pending = 1'b0;
        end

        exp_valid   = (fifo.size() != 0);
        exp_count   = fifo.size();
        exp_issue   = !rst && !flush && (fifo.size() + int'(pending) < DEPTH);
        exp_pcwrite = !rst && (exp_issue || flush);
        if (exp_valid) begin
            exp_pc    = fifo[0].pc;
            exp_instr = fifo[0].instr;
        end
        #1;
        mem_req_s  = IMemReq;
        mem_addr_s = IMemAddr;
    endtask

    always @(negedge Clk) begin
        #2;
        if (chk_en) begin
            check("valid", 32'(InstrValid), 32'(exp_valid));
            check("count", 32'(Count), exp_count);
            check("imemreq", 32'(IMemReq), 32'(exp_issue));
            check("pcwrite", 32'(PCWrite), 32'(exp_pcwrite));
            if (exp_issue) check("imemaddr", IMemAddr, PC);
            if (exp_valid) begin
                check("pcout", PCOut, exp_pc);
                check("instrout", InstrOut, exp_instr);
                check("pcplus4", PCPlus4Out, exp_pc + 32'd4);
            end
        end
    end

    task automatic reset2();
        rst_pc = 32'h0;
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        chk_en     = 1'b0;
        Reset      = 1'b1;
        Flush      = 1'b0;
        DecodeReady = 1'b0;
        PC         = 32'h0;
        IMemData   = 32'h0;
        cur_rst    = 1'b1;
        cur_flush  = 1'b0;
        cur_ready  = 1'b0;
        cur_target = 32'h0;
        pc_reg     = 32'h0;
        rst_pc     = 32'h0;
        pending    = 1'b0;
        pending_pc = 32'h0;
        mem_req_s  = 1'b0;
        mem_addr_s = 32'h0;
        exp_valid  = 1'b0;
        exp_issue  = 1'b0;
        exp_pcwrite = 1'b0;
        exp_count  = 32'h0;
        exp_pc     = 32'h0;
        exp_instr  = 32'h0;

        // Reset values and streaming
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk_en = 1'b1;
        #2;
        check("rst_pcout", PCOut, 32'h0);
        check("rst_pcplus4", PCPlus4Out, 32'h4);
        check("rst_instrout", InstrOut, 32'h0);
        check("rst_valid", 32'(InstrValid), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            #2;
            if (k == 1) check("stream_not_yet_valid", 32'(InstrValid), 32'h0);
            if (k == 2) begin
                check("stream_first_valid", 32'(InstrValid), 32'h1);
                check("stream_first_pc", PCOut, 32'h0);
                check("stream_first_instr", InstrOut, 32'hAB00_0000);
            end
            if (k == 3) check("stream_second_pc", PCOut, 32'h4);
        end

        // Backpressure fills the queue, then drains in order
        reset2();
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        check("bp_count_full", 32'(Count), 32'h4);
        check("bp_pcwrite_low", 32'(PCWrite), 32'h0);
        check("bp_imemreq_low", 32'(IMemReq), 32'h0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            #2;
            if (k == 0) check("bp_drain_pc0", PCOut, 32'h0);
            if (k == 1) check("bp_drain_pc4", PCOut, 32'h4);
            if (k == 4) check("bp_drain_pc16", PCOut, 32'h10);
        end

        // Flush with three queued entries and one read in flight
        reset2();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h20, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        check("flush_valid_low", 32'(InstrValid), 32'h0);
        check("flush_count_zero", 32'(Count), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        check("flush_target_valid", 32'(InstrValid), 32'h1);
        check("flush_target_pc", PCOut, 32'h20);

        // Simultaneous push and pop at count 3
        reset2();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        check("pushpop_count", 32'(Count), 32'h3);
        check("pushpop_head", PCOut, 32'h4);

        // Asynchronous reset with two entries and a read in flight
        reset2();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        rst_pc = 32'h100;
        step(1'b1, 1'b0, 32'h0, 1'b0);
        #2;
        check("midrst_valid", 32'(InstrValid), 32'h0);
        check("midrst_count", 32'(Count), 32'h0);
        check("midrst_imemreq", 32'(IMemReq), 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        check("midrst_first_pc", PCOut, 32'h100);

        // Address wrap at the top of the space
        step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            #2;
            if (k == 6) begin
                check("wrap_pc", PCOut, 32'hFFFF_FFFC);
                check("wrap_pcplus4", PCPlus4Out, 32'h0);
            end
            if (k == 7) check("wrap_next_pc", PCOut, 32'h0);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, f, d;
            logic [31:0] t;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 19) == 0);
            t = $urandom() & 32'hFFFF_FFFC;
            d = ($urandom_range(0, 3) < ((i / 500) % 5));
            if (r) rst_pc = $urandom() & 32'hFFFF_FFFC;
            step(r, f, t, d);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_en = 1'b0;
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
